// File: rtl/flt_sub_seq_if.sv
// ---------------------------------------------------------------------------
// flt_sub_seq_if
// Control handshake and byte-wide data memory port of the half-precision
// float subtractor.
//   start      : one-cycle request pulse (environment -> subtractor)
//   done       : result written, held until the next accepted start
//   mem_addr   : byte address into data_mem
//   mem_rd     : read strobe, mem_rdata valid one cycle later
//   mem_wr     : write strobe, mem_wdata written at mem_addr on the edge
//   mem_wdata  : write data byte
//   mem_rdata  : read data byte
// Modports: master = subtractor side, slave = memory/environment side.
// ---------------------------------------------------------------------------
interface flt_sub_seq_if;
    logic       start;
    logic       done;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic       mem_wr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    modport master (
        input  start,
        input  mem_rdata,
        output done,
        output mem_addr,
        output mem_rd,
        output mem_wr,
        output mem_wdata
    );

    modport slave (
        output start,
        output mem_rdata,
        input  done,
        input  mem_addr,
        input  mem_rd,
        input  mem_wr,
        input  mem_wdata
    );
endinterface

// File: rtl/flt_sub_seq.sv
// ---------------------------------------------------------------------------
// flt_sub_seq
// Multicycle half-precision subtractor computing A - B. Operands are fetched
// byte by byte from data_mem (A hi/lo at BASE_ADDR+0/+1, B at +2/+3), the
// result is written to +4 (hi) / +5 (lo) and done is raised.
// Format: sign[15], exp[14:10] bias 15, mant[9:0] with hidden 1; exp==0 is
// zero, no subnormals, no NaN; overflow saturates to +/-inf.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low reset
//   bus    : flt_sub_seq_if.master (start/done handshake + memory port)
// ---------------------------------------------------------------------------
module flt_sub_seq #(
    parameter logic [7:0] BASE_ADDR = 8'd128,
    parameter int         ALIGN_MAX = 13
) (
    input  logic          clk,
    input  logic          reset,
    flt_sub_seq_if.master bus
);

    localparam logic [4:0] ALIGN_LIM = 5'(ALIGN_MAX);

    typedef enum logic [3:0] {
        S_IDLE, S_LD0, S_LD1, S_LD2, S_LD3, S_LD4, S_PREP, S_ALIGN,
        S_ARITH, S_NORM, S_ROUND, S_WR0, S_WR1, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        done_q, done_d;
    logic        mem_rd_q, mem_rd_d;
    logic        mem_wr_q, mem_wr_d;
    logic [7:0]  mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic        sign_q, sign_d;
    logic        eff_sub_q, eff_sub_d;
    logic [5:0]  exp_q, exp_d;        // one spare bit so exp 31 + carry is seen
    logic [10:0] mx_q, mx_d;
    logic [10:0] my_q, my_d;
    logic [11:0] m_q, m_d;
    logic        g_q, g_d;
    logic        r_q, r_d;
    logic        s_q, s_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] res_q, res_d;

    // Operand ordering: X is the larger magnitude; exp/mant compare is the
    // same as an unsigned compare of the low 15 bits.
    logic        a_nil, b_nil, a_big;
    logic [4:0]  ex, ey, diff;
    logic [9:0]  x_mant, y_mant;
    logic [14:0] sub_w;
    logic [11:0] add_w;

    assign a_nil  = (a_q[14:10] == 5'd0);
    assign b_nil  = (b_q[14:10] == 5'd0);
    assign a_big  = (a_q[14:0] >= b_q[14:0]);
    assign ex     = a_big ? a_q[14:10] : b_q[14:10];
    assign ey     = a_big ? b_q[14:10] : a_q[14:10];
    assign x_mant = a_big ? a_q[9:0]   : b_q[9:0];
    assign y_mant = a_big ? b_q[9:0]   : a_q[9:0];
    assign diff   = ex - ey;

    // Subtraction includes the guard/round/sticky tail of Y so the borrow
    // out of the discarded bits reaches the mantissa.
    assign sub_w  = {1'b0, mx_q, 3'b000} - {1'b0, my_q, g_q, r_q, s_q};
    assign add_w  = {1'b0, mx_q} + {1'b0, my_q};

    // Round-to-nearest-even on a normalised 11-bit mantissa, then pack,
    // saturating to infinity when the exponent leaves the finite range.
    function automatic logic [15:0] round_pack(
        input logic        sign,
        input logic [5:0]  exp,
        input logic [10:0] mant,
        input logic        g,
        input logic        r,
        input logic        s
    );
        logic        inc;
        logic [11:0] sum;
        logic [5:0]  e;
        logic [9:0]  frac;
        inc  = g & (r | s | mant[0]);
        sum  = {1'b0, mant} + {11'b0, inc};
        e    = exp;
        frac = sum[9:0];
        if (sum[11]) begin
            e    = exp + 6'd1;
            frac = sum[10:1];
        end
        if (e >= 6'd31) begin
            return {sign, 5'h1f, 10'h000};
        end
        return {sign, e[4:0], frac};
    endfunction

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sign_d      = sign_q;
        eff_sub_d   = eff_sub_q;
        exp_d       = exp_q;
        mx_d        = mx_q;
        my_d        = my_q;
        m_d         = m_q;
        g_d         = g_q;
        r_d         = r_q;
        s_d         = s_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        done_d      = done_q;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = S_LD0;
                end
            end
            S_LD0: state_d = S_LD1;
            // Each LDn captures the byte requested in the previous cycle.
            S_LD1: begin
                a_d[15:8] = bus.mem_rdata;
                state_d   = S_LD2;
            end
            S_LD2: begin
                a_d[7:0] = bus.mem_rdata;
                state_d  = S_LD3;
            end
            S_LD3: begin
                b_d[15:8] = bus.mem_rdata;
                state_d   = S_LD4;
            end
            S_LD4: begin
                b_d[7:0] = bus.mem_rdata;
                state_d  = S_PREP;
            end
            S_PREP: begin
                if (a_nil && b_nil) begin
                    res_d   = 16'h0000;
                    state_d = S_WR0;
                end else if (a_nil) begin
                    res_d   = {~b_q[15], b_q[14:0]};
                    state_d = S_WR0;
                end else if (b_nil) begin
                    res_d   = a_q;
                    state_d = S_WR0;
                end else begin
                    // B's sign is inverted, so the effective operation is a
                    // subtraction exactly when the stored signs agree.
                    sign_d    = a_big ? a_q[15] : ~b_q[15];
                    eff_sub_d = (a_q[15] == b_q[15]);
                    exp_d     = {1'b0, ex};
                    mx_d      = {1'b1, x_mant};
                    g_d       = 1'b0;
                    r_d       = 1'b0;
                    if (diff > ALIGN_LIM) begin
                        my_d    = 11'd0;
                        s_d     = |{1'b1, y_mant};
                        cnt_d   = 5'd0;
                        state_d = S_ARITH;
                    end else begin
                        my_d    = {1'b1, y_mant};
                        s_d     = 1'b0;
                        cnt_d   = diff;
                        state_d = (diff == 5'd0) ? S_ARITH : S_ALIGN;
                    end
                end
            end
            S_ALIGN: begin
                my_d  = my_q >> 1;
                g_d   = my_q[0];
                r_d   = g_q;
                s_d   = s_q | r_q;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = S_ARITH;
                end
            end
            S_ARITH: begin
                if (eff_sub_q) begin
                    if (sub_w == 15'd0) begin
                        res_d   = 16'h0000;
                        state_d = S_WR0;
                    end else begin
                        m_d     = sub_w[14:3];
                        g_d     = sub_w[2];
                        r_d     = sub_w[1];
                        s_d     = sub_w[0];
                        state_d = S_NORM;
                    end
                end else begin
                    m_d     = add_w;
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                if (m_q[11]) begin
                    m_d     = {1'b0, m_q[11:1]};
                    g_d     = m_q[0];
                    r_d     = g_q;
                    s_d     = r_q | s_q;
                    exp_d   = exp_q + 6'd1;
                    state_d = S_ROUND;
                end else if (!m_q[10]) begin
                    m_d   = {m_q[10:0], g_q};
                    g_d   = r_q;
                    r_d   = s_q;
                    s_d   = 1'b0;
                    exp_d = exp_q - 6'd1;
                    // Exponent underflow flushes to a signed zero.
                    if (exp_q == 6'd1) begin
                        res_d   = {sign_q, 15'h0000};
                        state_d = S_WR0;
                    end
                end else begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                res_d   = round_pack(sign_q, exp_q, m_q[10:0], g_q, r_q, s_q);
                state_d = S_WR0;
            end
            S_WR0:   state_d = S_WR1;
            S_WR1:   state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase

        // Bus outputs are registered for the state being entered, so they
        // are stable for the whole cycle the FSM spends in that state.
        done_d = (state_d == S_DONE);
        case (state_d)
            S_LD0: begin
                mem_rd_d   = 1'b1;
                mem_addr_d = BASE_ADDR;
            end
            S_LD1: begin
                mem_rd_d   = 1'b1;
                mem_addr_d = BASE_ADDR + 8'd1;
            end
            S_LD2: begin
                mem_rd_d   = 1'b1;
                mem_addr_d = BASE_ADDR + 8'd2;
            end
            S_LD3: begin
                mem_rd_d   = 1'b1;
                mem_addr_d = BASE_ADDR + 8'd3;
            end
            S_WR0: begin
                mem_wr_d    = 1'b1;
                mem_addr_d  = BASE_ADDR + 8'd4;
                mem_wdata_d = res_d[15:8];
            end
            S_WR1: begin
                mem_wr_d    = 1'b1;
                mem_addr_d  = BASE_ADDR + 8'd5;
                mem_wdata_d = res_d[7:0];
            end
            default: begin
                mem_rd_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            done_q      <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= 8'd0;
            mem_wdata_q <= 8'd0;
            a_q         <= 16'd0;
            b_q         <= 16'd0;
            sign_q      <= 1'b0;
            eff_sub_q   <= 1'b0;
            exp_q       <= 6'd0;
            mx_q        <= 11'd0;
            my_q        <= 11'd0;
            m_q         <= 12'd0;
            g_q         <= 1'b0;
            r_q         <= 1'b0;
            s_q         <= 1'b0;
            cnt_q       <= 5'd0;
            res_q       <= 16'd0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sign_q      <= sign_d;
            eff_sub_q   <= eff_sub_d;
            exp_q       <= exp_d;
            mx_q        <= mx_d;
            my_q        <= my_d;
            m_q         <= m_d;
            g_q         <= g_d;
            r_q         <= r_d;
            s_q         <= s_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
        end
    end

    assign bus.done      = done_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: doc/flt_sub_seq.md
Name: flt_sub_seq

Overview:
Multicycle half-precision float subtractor: computes A − B, the inverse-direction companion of the float+float adder.
- Fetches operands from data_mem through a byte-wide memory port. A is at 128 (hi) / 129 (lo); B is at 130 (hi) / 131 (lo).
- Writes the result to 132 (hi) / 133 (lo), then raises done.
- Format: sign[15], exp[14:10] (bias 15), mant[9:0] with a hidden 1. exp==0 is treated as zero; no subnormals, no NaN.

Parameters:
BASE_ADDR, 8'd128, address of A hi byte; B at +2, result at +4
ALIGN_MAX, 13, maximum alignment shift; any larger exponent difference collapses entirely into sticky

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; begins an operation when idle
done  output  1  high when the result has been written; held until the next accepted start
mem_addr  output  8  data_mem address
mem_rd  output  1  read strobe; mem_rdata is valid on the following cycle
mem_wr  output  1  write strobe; writes mem_wdata at mem_addr on this edge
mem_wdata  output  8  write data
mem_rdata  input  8  read data, 1-cycle latency

Behaviour:
Reset (reset low, asynchronous):
- state=IDLE; done=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0; all datapath registers cleared.
- Reset mid-operation aborts immediately. A partial result write is allowed; done stays 0.

States: IDLE -> LD0..LD4 -> PREP -> ALIGN -> ARITH -> NORM -> ROUND -> WR0 -> WR1 -> DONE.
- IDLE/DONE: start=1 clears done and enters LD0. start while busy is ignored.
- LD0–LD3: issue reads of BASE+0..+3, one per cycle. Capture mem_rdata on the next cycle, so LD4 captures the last byte. Exactly 4 reads.
- PREP:
  - Negate B's sign.
  - Form 11-bit mantissas {!nil, mant}.
  - Swap the operands so that operand X has the larger magnitude (compare exp first, then mant). Result sign = X sign.
  - d = expX − expY. If d > ALIGN_MAX, set Y mant = 0 and sticky = (Y != 0).
- ALIGN: shift Y right 1 bit per cycle, d cycles (0 cycles if d=0).
  - guard <= Y[0]; round <= guard; sticky <= sticky|round.
- ARITH (1 cycle), on 12-bit sums:
  - Equal effective signs: M = X + Y.
  - Different effective signs: M = X − Y − borrow from {G,R,S}, subtracting the full {Y,G,R,S} extended value.
  - Exact zero result (X==Y, GRS=0): result 0x0000 (+0). Skip to WR0.
- NORM:
  - If M[11]=1: shift right once, exp+1, shifted-out bit into GRS.
  - Else, while M[10]=0: shift left 1 per cycle, guard shifts in, exp−1. At most 11 cycles.
  - exp reaching 0 flushes the result to ±0 (sign kept), then WR0.
- ROUND, round-to-nearest-even:
  - Increment when G && (R||S||M[0]).
  - A carry out of bit 10 shifts right and increments exp.
  - exp ≥ 31 after this step saturates to exp=31, mant=0 (±inf).
- WR0/WR1: write the hi byte {sign,exp,mant[9:8]} to BASE+4, then the lo byte mant[7:0] to BASE+5. One mem_wr per cycle.
- DONE: done=1, mem strobes low.
- Nil operands:
  - A zero: result = −B.
  - B zero: result = A.
  - Both zero: result = +0x0000.
- Latency from start: ≤ 4+1+1+13+1+11+1+2+1 = 35 cycles; minimum 9.

Test Plan:
- A=0x4200 (3.0), B=0x3C00 (1.0) -> 0x4000 at 132/133; done within 35 cycles; exactly 4 reads, 2 writes.
- A=0x3C00, B=0x3C00 -> 0x0000 (+0); NORM skipped.
- A=0x3C00, B=0xBC00 (−1.0) -> effective add, mantissa overflow right-shift -> 0x4000.
- A=0x3C00, B=0x3C01 -> −2^-10 = 0x9400; NORM takes 10 left-shift cycles; sign from swapped operand.
- A=0x3C00, B=0x0C00 (2^-12) -> guard=1 rounds up with carry-out -> 0x3C00, exp restored to 15.
- Pulse start with A=0x4200, B=0x3C00; assert reset low during ALIGN -> done=0 and strobes 0 immediately (asynchronous); after release, state IDLE; a fresh start gives the correct 0x4000.
